// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side consumer.
// Default data width and the matching word type.
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int SKID_DEPTH     = 2;
  typedef logic [DEF_DATA_WIDTH-1:0] fifo_data_t;
endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order output buffer: push into tail, pop from head, clear drops all.
// Push and pop in the same cycle are allowed at any non-zero occupancy.
module fifo_reader_skid
  import fifo_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);
  logic [W-1:0] tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (clear) begin
      occ <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= din;
          else             tail <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        // occupancy unchanged; the new word lands behind whatever remains
        2'b11: begin
          if (occ == 2'd1) head <= din;
          else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fifo_reader.sv
// FIFO read-port consumer re-presenting popped words as a valid/ready stream.
// Optional pop counter enabled with `define FIFO_READER_STATS_EN.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [31:0]           pop_cnt
`endif
);
  logic [1:0] occ;
  logic       inflight;
  logic       accept;
  logic [2:0] committed;

  assign m_valid   = (occ != 2'd0);
  assign accept    = m_valid & m_ready;
  assign committed = {1'b0, occ} + {2'b00, inflight};

  // Credit check counts the word already in flight so the buffer never overflows.
  always_comb begin
    rd_en = 1'b0;
    if (en && !empty && !flush && !reset)
      rd_en = (committed < 3'(SKID_DEPTH)) ||
              ((committed == 3'(SKID_DEPTH)) && accept);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) inflight <= 1'b0;
    else                inflight <= rd_en;
  end

  fifo_reader_skid #(.W(DATA_WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (inflight & ~flush),
    .pop   (accept),
    .din   (rd_data),
    .occ   (occ),
    .head  (m_data)
  );

`ifdef FIFO_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)      pop_cnt <= '0;
    else if (rd_en) pop_cnt <= pop_cnt + 32'd1;
  end
`endif
endmodule
